// File: rtl/fifo_drain_if.sv
// Handshake bundle between fifo_drain_ctrl, the FIFO read port and the downstream stream.
// master = the drain controller, slave = the FIFO/consumer side.
interface fifo_drain_if #(
  parameter int W_DATA = 8,
  parameter int W_LEN  = 8
);
  logic              req_start;
  logic [W_LEN-1:0]  req_len;
  logic              fifo_empty;
  logic [W_DATA-1:0] fifo_rd_data;
  logic              fifo_pop;
  logic [W_DATA-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              busy;
  logic              done;
  logic [W_LEN-1:0]  words_left;
  logic [15:0]       stall_cnt;

  modport master (
    input  req_start, req_len, fifo_empty, fifo_rd_data, out_ready,
    output fifo_pop, out_data, out_valid, busy, done, words_left, stall_cnt
  );
  modport slave (
    output req_start, req_len, fifo_empty, fifo_rd_data, out_ready,
    input  fifo_pop, out_data, out_valid, busy, done, words_left, stall_cnt
  );
endinterface

// File: rtl/fifo_drain_ctrl.sv
// Drains req_len words from a registered-read FIFO into a 2-entry skid buffer feeding a valid/ready stream.
// Optional macro DRAIN_STALL_CNT_EN enables the saturating backpressure counter on stall_cnt.
module fifo_drain_ctrl #(
  parameter int W_DATA = 8,
  parameter int W_LEN  = 8
) (
  input logic          clk,
  input logic          rst,
  fifo_drain_if.master bus
);
  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  state_t            state, state_nx;
  logic [W_LEN-1:0]  pop_left, words_left;
  logic [1:0]        occ;
  logic              infl;
  logic [W_DATA-1:0] sb0, sb1;
  logic              deq, start_ok, last, pop, done_q;

  assign deq      = (occ != 2'd0) & bus.out_ready;
  assign start_ok = bus.req_start & (state == IDLE);
  assign last     = deq & (words_left == W_LEN'(1));

  always_comb begin
    state_nx = state;
    pop      = 1'b0;
    case (state)
      IDLE:  if (start_ok && bus.req_len != '0) state_nx = RUN;
      RUN: begin
        if (pop_left == '0) state_nx = FLUSH;
        // An in-flight read already owns a buffer slot.
        pop = !bus.fifo_empty && (pop_left != '0) &&
              (({1'b0, occ} + {2'b0, infl}) < (3'd2 + {2'b0, deq}));
      end
      FLUSH: if (last) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      pop_left   <= '0;
      words_left <= '0;
      infl       <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state  <= state_nx;
      infl   <= pop;
      done_q <= (start_ok && bus.req_len == '0) || (state == FLUSH && last);
      if (start_ok && bus.req_len != '0) begin
        pop_left   <= bus.req_len;
        words_left <= bus.req_len;
      end else begin
        if (pop) pop_left   <= pop_left - W_LEN'(1);
        if (deq) words_left <= words_left - W_LEN'(1);
      end
    end
  end

  // Skid buffer: sb0 is the head; read data lands at the tail the cycle after the pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ <= 2'd0;
      sb0 <= '0;
      sb1 <= '0;
    end else begin
      case ({infl, deq})
        2'b10: begin
          if (occ == 2'd0) sb0 <= bus.fifo_rd_data;
          else             sb1 <= bus.fifo_rd_data;
          occ <= occ + 2'd1;
        end
        2'b01: begin
          sb0 <= sb1;
          occ <= occ - 2'd1;
        end
        2'b11: begin
          if (occ == 2'd1) sb0 <= bus.fifo_rd_data;
          else begin
            sb0 <= sb1;
            sb1 <= bus.fifo_rd_data;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef DRAIN_STALL_CNT_EN
  logic [15:0] stall_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                                   stall_q <= '0;
    else if (start_ok)                                         stall_q <= '0;
    else if (occ != 2'd0 && !bus.out_ready && stall_q != 16'hFFFF) stall_q <= stall_q + 16'd1;
  end
  assign bus.stall_cnt = stall_q;
`else
  assign bus.stall_cnt = 16'd0;
`endif

  assign bus.fifo_pop   = pop;
  assign bus.out_data   = sb0;
  assign bus.out_valid  = occ != 2'd0;
  assign bus.busy       = state != IDLE;
  assign bus.done       = done_q;
  assign bus.words_left = words_left;
endmodule

// File: tb/tb_fifo_drain_ctrl.sv
// Directed bench for fifo_drain_ctrl with a behavioural registered-read FIFO on its input side.
module tb_fifo_drain_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;

  fifo_drain_if #(.W_DATA(8), .W_LEN(8)) bus ();
  fifo_drain_ctrl #(.W_DATA(8), .W_LEN(8)) dut (.clk(clk), .rst(rst), .bus(bus.master));

  always #5 clk = ~clk;

`ifdef DRAIN_STALL_CNT_EN
  localparam logic [15:0] EXP_STALL = 16'd5;
`else
  localparam logic [15:0] EXP_STALL = 16'd0;
`endif

  // Registered-read FIFO model: rd_data updates on the edge that consumes the pop.
  logic [7:0] fmem [0:15];
  logic [3:0] wp, rp;
  logic [4:0] fcnt;
  logic       push = 1'b0;
  logic [7:0] push_data = 8'h00;
  logic       fclr = 1'b0;
  int         pop_total = 0;

  always @(posedge clk) begin
    if (fclr) begin
      wp <= '0; rp <= '0; fcnt <= '0;
      bus.fifo_rd_data <= 8'h00;
    end else begin
      if (bus.fifo_pop && fcnt != 5'd0) begin
        bus.fifo_rd_data <= fmem[rp];
        rp <= rp + 4'd1;
      end
      if (push) begin
        fmem[wp] <= push_data;
        wp <= wp + 4'd1;
      end
      fcnt <= fcnt + 5'(push) - 5'(bus.fifo_pop && fcnt != 5'd0);
    end
    if (bus.fifo_pop) pop_total <= pop_total + 1;
  end
  assign bus.fifo_empty = (fcnt == 5'd0);

  task automatic nxt;
    @(negedge clk);
    bus.req_start = 1'b0;
    #1;
  endtask

  task automatic start(input logic [7:0] len);
    @(negedge clk);
    bus.req_len   = len;
    bus.req_start = 1'b1;
    #1;
  endtask

  task automatic fclear;
    @(negedge clk); fclr = 1'b1;
    @(negedge clk); fclr = 1'b0;
  endtask

  task automatic load(input logic [7:0] first, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      push = 1'b1;
      push_data = first + 8'(i * 17);
    end
    @(negedge clk);
    push = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge clk); #1;
    n_chk++;
    if ({bus.fifo_pop, bus.out_valid, bus.busy, bus.done} !== 4'b0000 || bus.words_left !== 8'd0 ||
        bus.stall_cnt !== 16'd0 || bus.out_data !== 8'd0) begin
      n_fail++;
      $display("FAIL reset: pop=%b vld=%b busy=%b done=%b wl=%0d stall=%0d data=%h, want all 0",
               bus.fifo_pop, bus.out_valid, bus.busy, bus.done, bus.words_left, bus.stall_cnt, bus.out_data);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic;
    logic [7:0] exp_d [4];
    int p0;
    exp_d = '{8'h11, 8'h22, 8'h33, 8'h44};
    fclear;
    load(8'h11, 4);
    bus.out_ready = 1'b1;
    p0 = pop_total;
    start(8'd4);
    n_chk++;
    if (bus.fifo_pop !== 1'b0) begin n_fail++; $display("FAIL basic_k0_pop: got %b want 0", bus.fifo_pop); end
    for (int k = 1; k <= 7; k++) begin
      nxt;
      n_chk++;
      if (bus.fifo_pop !== (k <= 4)) begin
        n_fail++; $display("FAIL basic_pop k=%0d: got %b want %b", k, bus.fifo_pop, k <= 4);
      end
      n_chk++;
      if (bus.out_valid !== (k >= 3 && k <= 6)) begin
        n_fail++; $display("FAIL basic_valid k=%0d: got %b", k, bus.out_valid);
      end
      if (k >= 3 && k <= 6) begin
        n_chk++;
        if (bus.out_data !== exp_d[k-3]) begin
          n_fail++; $display("FAIL basic_data k=%0d: got %h want %h", k, bus.out_data, exp_d[k-3]);
        end
      end
      n_chk++;
      if (bus.done !== (k == 7)) begin
        n_fail++; $display("FAIL basic_done k=%0d: got %b", k, bus.done);
      end
    end
    n_chk++;
    if (bus.words_left !== 8'd0 || bus.busy !== 1'b0 || pop_total - p0 != 4) begin
      n_fail++; $display("FAIL basic_end: wl=%0d busy=%b pops=%0d want 0 0 4", bus.words_left, bus.busy, pop_total - p0);
    end
  endtask

  task automatic test_backpressure;
    logic [7:0] rec [8];
    int p0, got;
    fclear;
    load(8'h01, 5);          // 01,12,23,34,45
    bus.out_ready = 1'b0;
    p0 = pop_total;
    start(8'd3);
    for (int k = 1; k <= 7; k++) begin
      nxt;
      if (k >= 3) begin
        n_chk++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h01) begin
          n_fail++; $display("FAIL bp_hold k=%0d: vld=%b data=%h want 1 01", k, bus.out_valid, bus.out_data);
        end
      end
    end
    n_chk++;
    if (pop_total - p0 != 2) begin n_fail++; $display("FAIL bp_pops_stalled: got %0d want 2", pop_total - p0); end
    nxt;
    bus.out_ready = 1'b1;
    got = 0;
    for (int i = 0; i < 20 && !bus.done; i++) begin
      if (bus.out_valid && bus.out_ready && got < 8) begin rec[got] = bus.out_data; got++; end
      nxt;
    end
    n_chk++;
    if (bus.done !== 1'b1 || got != 3) begin
      n_fail++; $display("FAIL bp_complete: done=%b words=%0d want 1 3", bus.done, got);
    end else begin
      n_chk++;
      if (rec[0] !== 8'h01 || rec[1] !== 8'h12 || rec[2] !== 8'h23) begin
        n_fail++; $display("FAIL bp_order: got %h %h %h want 01 12 23", rec[0], rec[1], rec[2]);
      end
    end
    n_chk++;
    if (pop_total - p0 != 3 || fcnt !== 5'd2) begin
      n_fail++; $display("FAIL bp_pops_total: pops=%0d left=%0d want 3 2", pop_total - p0, fcnt);
    end
    n_chk++;
    if (bus.stall_cnt !== EXP_STALL) begin
      n_fail++; $display("FAIL bp_stall_cnt: got %0d want %0d", bus.stall_cnt, EXP_STALL);
    end
  endtask

  task automatic test_empty;
    logic [7:0] rec [8];
    int got, ndone;
    fclear;
    bus.out_ready = 1'b1;
    start(8'd2);
    for (int k = 1; k <= 4; k++) begin
      nxt;
      if (k == 4) begin push = 1'b1; push_data = 8'hA5; #1; end
      n_chk++;
      if (bus.fifo_pop !== 1'b0 || bus.busy !== 1'b1) begin
        n_fail++; $display("FAIL empty_nopop k=%0d: pop=%b busy=%b want 0 1", k, bus.fifo_pop, bus.busy);
      end
    end
    nxt;
    push_data = 8'h5A;
    got = 0; ndone = 0;
    for (int i = 0; i < 20; i++) begin
      if (i == 1) push = 1'b0;
      if (bus.fifo_pop && bus.fifo_empty) begin
        n_chk++; n_fail++; $display("FAIL empty_pop_while_empty: pop=1 empty=1 at i=%0d", i);
      end
      if (bus.out_valid && bus.out_ready && got < 8) begin rec[got] = bus.out_data; got++; end
      if (bus.done) ndone++;
      nxt;
    end
    n_chk++;
    if (got != 2 || rec[0] !== 8'hA5 || rec[1] !== 8'h5A) begin
      n_fail++; $display("FAIL empty_data: n=%0d first=%h second=%h want 2 a5 5a", got, rec[0], rec[1]);
    end
    n_chk++;
    if (ndone != 1) begin n_fail++; $display("FAIL empty_done_once: got %0d pulses want 1", ndone); end
  endtask

  task automatic test_zero_len;
    int p0;
    p0 = pop_total;
    start(8'd0);
    n_chk++;
    if (bus.fifo_pop !== 1'b0 || bus.done !== 1'b0) begin
      n_fail++; $display("FAIL zero_k0: pop=%b done=%b want 0 0", bus.fifo_pop, bus.done);
    end
    nxt;
    n_chk++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.fifo_pop !== 1'b0) begin
      n_fail++; $display("FAIL zero_k1: done=%b busy=%b pop=%b want 1 0 0", bus.done, bus.busy, bus.fifo_pop);
    end
    nxt;
    n_chk++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0 || pop_total != p0) begin
      n_fail++; $display("FAIL zero_k2: done=%b busy=%b pops=%0d want 0 0 0", bus.done, bus.busy, pop_total - p0);
    end
  endtask

  task automatic test_mid_reset;
    logic [7:0] got_d;
    int got;
    fclear;
    load(8'h61, 6);          // 61,72,83,94,a5,b6
    bus.out_ready = 1'b1;
    start(8'd6);
    for (int k = 1; k <= 4; k++) begin
      nxt;
      if (k >= 3) begin
        n_chk++;
        if (bus.out_data !== (k == 3 ? 8'h61 : 8'h72)) begin
          n_fail++; $display("FAIL rst_pre_data k=%0d: got %h", k, bus.out_data);
        end
      end
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_chk++;
    if ({bus.fifo_pop, bus.out_valid, bus.busy, bus.done} !== 4'b0000 || bus.words_left !== 8'd0 ||
        bus.stall_cnt !== 16'd0 || bus.out_data !== 8'd0) begin
      n_fail++; $display("FAIL rst_mid: pop=%b vld=%b busy=%b done=%b wl=%0d data=%h want all 0",
                         bus.fifo_pop, bus.out_valid, bus.busy, bus.done, bus.words_left, bus.out_data);
    end
    nxt;
    n_chk++;
    if (bus.done !== 1'b0) begin n_fail++; $display("FAIL rst_no_done: got %b want 0", bus.done); end
    rst = 1'b0;
    start(8'd1);
    got = 0; got_d = 8'h00;
    for (int i = 0; i < 20 && !bus.done; i++) begin
      if (bus.out_valid && bus.out_ready) begin got_d = bus.out_data; got++; end
      nxt;
    end
    n_chk++;
    if (bus.done !== 1'b1 || got != 1 || got_d !== 8'hA5 || fcnt !== 5'd1) begin
      n_fail++; $display("FAIL rst_resume: done=%b n=%0d data=%h left=%0d want 1 1 a5 1", bus.done, got, got_d, fcnt);
    end
  endtask

  task automatic test_restart_ignored;
    logic [7:0] exp_wl [7];
    int p0;
    exp_wl = '{8'd4, 8'd4, 8'd4, 8'd3, 8'd2, 8'd1, 8'd0};
    fclear;
    load(8'h71, 6);
    bus.out_ready = 1'b1;
    p0 = pop_total;
    start(8'd4);
    for (int k = 1; k <= 7; k++) begin
      nxt;
      if (k == 2) begin bus.req_start = 1'b1; bus.req_len = 8'd9; #1; end
      n_chk++;
      if (bus.words_left !== exp_wl[k-1]) begin
        n_fail++; $display("FAIL restart_wl k=%0d: got %0d want %0d", k, bus.words_left, exp_wl[k-1]);
      end
      n_chk++;
      if (bus.done !== (k == 7) || bus.busy !== (k != 7)) begin
        n_fail++; $display("FAIL restart_ctl k=%0d: done=%b busy=%b", k, bus.done, bus.busy);
      end
    end
    n_chk++;
    if (pop_total - p0 != 4) begin n_fail++; $display("FAIL restart_pops: got %0d want 4", pop_total - p0); end
  endtask

  initial begin
    bus.req_start = 1'b0;
    bus.req_len   = 8'd0;
    bus.out_ready = 1'b0;
    test_reset;
    test_basic;
    test_backpressure;
    test_empty;
    test_zero_len;
    test_mid_reset;
    test_restart_ignored;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
